i2c_read_master: RTL

Parametrised I2C master that performs a complete single-master read transaction from a fixed 7-bit slave address. The sequence is START, address+R, slave ACK, NUM_BYTES data bytes with master ACK/NACK, then STOP. The block drives open-drain SCL/SDA from a single system clock and presents the assembled read word with a one-cycle valid pulse. It reports an address NACK, and optionally honours slave clock stretching. It sits between the pad-level I2C bus and sensor-readout logic, as the successor to the address-only master.

---
 rtl/i2c_read_master.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_read_master.sv
// Single-master I2C read: START, {SLAVE_ADDR,R}, slave ACK, NUM_BYTES bytes with ACK/NACK, STOP.
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching on SCL.
`timescale 1ns/1ps
module i2c_read_master #(
    parameter logic [6:0] SLAVE_ADDR = 7'h7F,
    parameter int         CLK_DIV    = 250,
    parameter int         NUM_BYTES  = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    output logic                   busy,
    output logic [8*NUM_BYTES-1:0] data_out,
    output logic                   data_valid,
    output logic                   ack_err,
    inout  wire                    scl,
    inout  wire                    sda
);

    localparam int Q  = CLK_DIV / 4;
    localparam int CW = $clog2(CLK_DIV);
    localparam int DW = 8 * NUM_BYTES;
    localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [7:0]    ADDR_BYTE = {SLAVE_ADDR, 1'b1};
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] Q1_START  = CW'(Q);
    localparam logic [CW-1:0] Q2_START  = CW'(2 * Q);
    localparam logic [CW-1:0] Q3_START  = CW'(3 * Q);
    localparam logic [CW-1:0] SAMPLE_AT = CW'(3 * Q - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE, START, ADDR, ADDR_ACK, READ_BYTE, READ_ACK, STOP, DONE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_cnt;
    logic [BW-1:0]   byte_cnt;
    logic [7:0]      shift_byte;
    logic [DW-1:0]   staging;
    logic            ack_bit;
    logic [1:0]      sda_sync;
    logic            scl_low, sda_low;
    logic            freeze, phase_end, sample_pt;

    assign scl = scl_low ? 1'b0 : 1'bz;
    assign sda = sda_low ? 1'b0 : 1'bz;

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] scl_sync;
    logic [1:0] scl_low_hist;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_sync     <= 2'b00;
            scl_low_hist <= 2'b00;
        end else begin
            scl_sync     <= {scl_sync[0], scl};
            scl_low_hist <= {scl_low_hist[0], scl_low};
        end
    end

    // Only trust the synchronizer once SCL has been released for its full latency;
    // a low reading after that means a slave is holding the clock.
    assign freeze = !scl_low && (scl_low_hist == 2'b00) && !scl_sync[1];
`else
    assign freeze = 1'b0;
`endif

    assign phase_end = (cnt == CNT_LAST) && !freeze;
    assign sample_pt = (cnt == SAMPLE_AT) && !freeze;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        scl_low   = 1'b0;
        sda_low   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = START;
            end
            START: begin
                sda_low = (cnt >= Q2_START);
                scl_low = (cnt >= Q3_START);
                if (phase_end) state_nxt = ADDR;
            end
            ADDR: begin
                scl_low = (cnt < Q2_START);
                sda_low = !ADDR_BYTE[3'd7 - bit_cnt];
                if (phase_end && bit_cnt == 3'd7) state_nxt = ADDR_ACK;
            end
            ADDR_ACK: begin
                scl_low = (cnt < Q2_START);
                if (phase_end) state_nxt = ack_bit ? STOP : READ_BYTE;
            end
            READ_BYTE: begin
                scl_low = (cnt < Q2_START);
                if (phase_end && bit_cnt == 3'd7) state_nxt = READ_ACK;
            end
            READ_ACK: begin
                scl_low = (cnt < Q2_START);
                sda_low = (byte_cnt != LAST_BYTE);
                if (phase_end) state_nxt = (byte_cnt == LAST_BYTE) ? STOP : READ_BYTE;
            end
            STOP: begin
                scl_low = (cnt < Q1_START);
                sda_low = (cnt < Q2_START);
                if (phase_end) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            ack_err    <= 1'b0;
            cnt        <= '0;
            bit_cnt    <= 3'd0;
            byte_cnt   <= '0;
            shift_byte <= 8'd0;
            staging    <= '0;
            ack_bit    <= 1'b0;
            sda_sync   <= 2'b00;
        end else begin
            data_valid <= 1'b0;
            busy       <= (state != IDLE);
            sda_sync   <= {sda_sync[0], sda};

            if (state == IDLE || state == DONE || phase_end) cnt <= '0;
            else if (!freeze)                                cnt <= cnt + 1'b1;

            case (state)
                IDLE: begin
                    bit_cnt  <= 3'd0;
                    byte_cnt <= '0;
                    if (start) ack_err <= 1'b0;
                end
                ADDR: begin
                    if (phase_end) bit_cnt <= bit_cnt + 3'd1;
                end
                ADDR_ACK: begin
                    if (sample_pt)            ack_bit <= sda_sync[1];
                    if (phase_end && ack_bit) ack_err <= 1'b1;
                end
                READ_BYTE: begin
                    if (sample_pt) shift_byte <= {shift_byte[6:0], sda_sync[1]};
                    if (phase_end) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            // First byte lands in the MSBs of the staging word.
                            for (int i = 0; i < NUM_BYTES; i++) begin
                                if (byte_cnt == BW'(i)) staging[DW-1-8*i -: 8] <= shift_byte;
                            end
                        end
                    end
                end
                READ_ACK: begin
                    if (phase_end) byte_cnt <= byte_cnt + 1'b1;
                end
                DONE: begin
                    if (!ack_err) begin
                        data_out   <= staging;
                        data_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
